fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem handshake and the IF/ID pipeline register.
// Handles load-use stalls (HOLD), redirects with an outstanding request (DROP) and flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } state_t;

    state_t      state, state_nxt;
    logic        req_en;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] hold_buf, hold_buf_nxt;
    logic [31:0] target;
    logic        load;
    logic [31:0] load_inst;

    assign target = redirect_target & ~32'd3;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        hold_buf_nxt  = hold_buf;
        load          = 1'b0;
        load_inst     = hold_buf;
        imem_req      = 1'b0;
        imem_addr     = pc;
        // Nothing is requested until the first edge after reset release.
        if (req_en) begin
            unique case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if (redirect_valid) begin
                            pc_nxt = target;
                        end else if (pc_write && ifid_write) begin
                            load      = 1'b1;
                            load_inst = imem_rdata;
                            pc_nxt    = pc + 32'd4;
                        end else begin
                            hold_buf_nxt = imem_rdata;
                            state_nxt    = HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop_addr_nxt = pc;
                        pc_nxt        = target;
                        state_nxt     = DROP;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end else if (pc_write && ifid_write) begin
                        load      = 1'b1;
                        load_inst = hold_buf;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = FETCH;
                    end
                end
                DROP: begin
                    // Keep the stale request stable until memory answers, then discard it.
                    imem_req  = 1'b1;
                    imem_addr = drop_addr;
                    if (redirect_valid) pc_nxt = target;
                    if (imem_ready) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            req_en    <= 1'b0;
            pc        <= RESET_PC;
            drop_addr <= '0;
            hold_buf  <= '0;
        end else begin
            state     <= state_nxt;
            req_en    <= 1'b1;
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
            hold_buf  <= hold_buf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end else if (ifid_write) begin
            if (load) begin
                id_valid <= 1'b1;
                id_inst  <= load_inst;
                id_pc    <= pc;
            end else begin
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
            end
        end
    end

    assign id_pc_plus4 = id_pc + 32'd4;
    assign fetch_busy  = (state != FETCH);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage with a transaction-level model
// plus directed scenarios pinned by literal expectations.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, ifid_write, flush, redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst, id_pc, id_pc_plus4;
    logic        fetch_busy;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ifid_write(ifid_write),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    // Model: memory contents are a fixed function of the address.
    logic        m_started, m_dropping, m_held;
    logic [31:0] m_pc, m_drop_addr, m_hold_inst;
    logic        e_valid;
    logic [31:0] e_inst, e_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic exp_req();
        return m_started && !m_held;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_dropping ? m_drop_addr : m_pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
        chk("fetch_busy", 32'(fetch_busy), 32'(m_dropping || m_held));
        chk("id_valid", 32'(id_valid), 32'(e_valid));
        chk("id_inst", id_inst, e_inst);
        chk("id_pc", id_pc, e_pc);
        chk("id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
    endtask

    task automatic model_reset();
        m_started = 0; m_dropping = 0; m_held = 0;
        m_pc = RPC; m_drop_addr = '0; m_hold_inst = '0;
        e_valid = 0; e_inst = NOP; e_pc = '0;
    endtask

    task automatic check_reset_values();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, NOP);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'd4);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
    endtask

    task automatic do_reset();
        pc_write = 1; ifid_write = 1; flush = 0; redirect_valid = 0;
        redirect_target = '0; imem_ready = 0; imem_rdata = '0;
        #2 rst = 1;
        #1 check_reset_values();
        model_reset();
        @(posedge clk); #1;
        check_reset_values();
        rst = 0;
    endtask

    // One clock: apply inputs, check outputs against the model, advance the model.
    task automatic step(input logic pw, input logic iw, input logic fl, input logic rv,
                        input logic [31:0] rt, input logic rdy);
        logic        ld;
        logic [31:0] li, lp, ta;
        pc_write = pw; ifid_write = iw; flush = fl; redirect_valid = rv;
        redirect_target = rt; imem_ready = rdy;
        imem_rdata = exp_req() ? mem(exp_addr()) : $urandom;
        #1 compare_all();
        ld = 0; li = '0; lp = m_pc; ta = {rt[31:2], 2'b00};
        if (m_started) begin
            if (m_dropping) begin
                if (rv) m_pc = ta;
                if (rdy) m_dropping = 0;
            end else if (m_held) begin
                if (rv) begin
                    m_held = 0; m_pc = ta;
                end else if (pw && iw) begin
                    ld = 1; li = m_hold_inst; m_pc = m_pc + 4; m_held = 0;
                end
            end else if (rdy) begin
                if (rv) m_pc = ta;
                else if (pw && iw) begin
                    ld = 1; li = mem(m_pc); m_pc = m_pc + 4;
                end else begin
                    m_held = 1; m_hold_inst = mem(m_pc);
                end
            end else if (rv) begin
                m_dropping = 1; m_drop_addr = m_pc; m_pc = ta;
            end
        end
        m_started = 1;
        if (fl) begin
            e_valid = 0; e_inst = NOP;
        end else if (iw) begin
            if (ld) begin
                e_valid = 1; e_inst = li; e_pc = lp;
            end else begin
                e_valid = 0; e_inst = NOP;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1;
        do_reset();

        // Release: first edge raises imem_req at RESET_PC, then one instruction per cycle.
        step(1, 1, 0, 0, 0, 0);
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h3000);
        step(1, 1, 0, 0, 0, 1);
        chk("seq0_pc", id_pc, 32'h3000);
        chk("seq0_valid", 32'(id_valid), 32'd1);
        step(1, 1, 0, 0, 0, 1);
        chk("seq1_pc", id_pc, 32'h3004);
        step(1, 1, 0, 0, 0, 1);
        chk("seq2_pc", id_pc, 32'h3008);

        // Load-use stall with a ready response -> HOLD, then release without gap or repeat.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("hold_busy", 32'(fetch_busy), 32'd1);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_idpc", id_pc, 32'h3008);
        end
        step(1, 1, 0, 0, 0, 0);
        chk("rel_idpc", id_pc, 32'h300C);
        chk("rel_inst", id_inst, mem(32'h300C));
        step(1, 1, 0, 0, 0, 1);
        chk("after_hold_pc", id_pc, 32'h3010);

        // Redirect while a request is outstanding -> DROP.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h0000_3040, 0);
        chk("drop_busy", 32'(fetch_busy), 32'd1);
        chk("drop_addr", imem_addr, 32'h3014);
        step(1, 1, 0, 0, 0, 1);
        chk("drop_discard", 32'(id_valid), 32'd0);
        chk("drop_newaddr", imem_addr, 32'h3040);
        step(1, 1, 0, 0, 0, 1);
        chk("redir_pc", id_pc, 32'h3040);
        chk("redir_valid", 32'(id_valid), 32'd1);

        // Flush beats a valid load.
        step(1, 1, 1, 0, 0, 1);
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_inst", id_inst, NOP);

        // Misaligned redirect near the top of memory, and PC wrap.
        step(1, 1, 0, 1, 32'hFFFF_FFFE, 1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0, 1);
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);
        step(1, 1, 0, 0, 0, 1);
        chk("wrap_zero", id_pc, 32'h0);

        // Reset while in DROP.
        step(1, 1, 0, 1, 32'h0000_5000, 0);
        chk("pre_rst_busy", 32'(fetch_busy), 32'd1);
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        chk("post_rst_addr", imem_addr, 32'h3000);
        step(1, 1, 0, 0, 0, 1);
        chk("post_rst_idpc", id_pc, 32'h3000);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic        stall;
            logic [31:0] tgt;
            stall = ($urandom_range(0, 99) < 20);
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_FFFF);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(stall ? 1'($urandom) : 1'b1, stall ? 1'b0 : 1'b1,
                     $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
                     tgt, $urandom_range(0, 99) < 70);
            end
        end
        #1 compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
